// File: rtl/video_clock_seq.sv
// video_clock_seq: pixel-clock select sequencer holding HDMI in reset across PLL reprogramming
module video_clock_seq #(
   parameter logic [3:0] DEFAULT_CONFIG = 4'd0,
   parameter int         HOLD_CYCLES    = 16,
   parameter int         DROP_CYCLES    = 8,
   parameter int         SETTLE_CYCLES  = 1024,
   parameter int         LOCK_TIMEOUT   = 2700000
) (
   input  logic       clk27,
   input  logic       rstn,
   input  logic       lock,
   input  logic       req_valid,
   input  logic [3:0] req_config,
   output logic       req_ready,
   output logic [3:0] clock_config,
   output logic       hdmi_rstn_o,
   output logic       busy,
   output logic       cfg_err,
   output logic [7:0] lost_cnt
);
   localparam int M1   = HOLD_CYCLES > DROP_CYCLES ? HOLD_CYCLES : DROP_CYCLES;
   localparam int M2   = SETTLE_CYCLES > LOCK_TIMEOUT ? SETTLE_CYCLES : LOCK_TIMEOUT;
   localparam int MAXV = M1 > M2 ? M1 : M2;
   localparam int CW   = $clog2(MAXV + 1);
   typedef enum logic [2:0] {HOLD, DROP, WAIT_LOCK, SETTLE, RUN} state_t;
   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [3:0]      cfg_q, cfg_d, pend_q, pend_d;
   logic            err_q, err_d;
   logic [7:0]      lost_q, lost_d;
   logic            lock_m_q, lock_s_q;
   logic            rdy_q, hrst_q, busy_q;
   logic            last;
   assign last = cnt_q == CW'(1);
   // Next-state logic: the shared counter exits a timed state on the edge where it reads 1
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q - CW'(1);
      cfg_d   = cfg_q;
      pend_d  = pend_q;
      err_d   = err_q;
      lost_d  = lost_q;
      case (state_q)
         HOLD: if (last) begin
            state_d = DROP;
            cnt_d   = CW'(DROP_CYCLES);
            cfg_d   = pend_q;
         end
         DROP: if (last) begin
            state_d = WAIT_LOCK;
            cnt_d   = CW'(LOCK_TIMEOUT);
         end
         WAIT_LOCK: if (lock_s_q) begin
            state_d = SETTLE;
            cnt_d   = CW'(SETTLE_CYCLES);
         end else if (last) begin
            state_d = DROP;
            cnt_d   = CW'(DROP_CYCLES);
            cfg_d   = DEFAULT_CONFIG;
            err_d   = 1'b1;
         end
         SETTLE: if (!lock_s_q) begin
            state_d = WAIT_LOCK;
            cnt_d   = CW'(LOCK_TIMEOUT);
         end else if (last) state_d = RUN;
         RUN: begin
            cnt_d = cnt_q;
            if (req_valid) begin
               err_d = 1'b0;
               if (req_config != cfg_q) begin
                  pend_d  = req_config;
                  state_d = HOLD;
                  cnt_d   = CW'(HOLD_CYCLES);
               end
            end
            if (!lock_s_q && state_d == RUN) begin
               state_d = WAIT_LOCK;
               cnt_d   = CW'(LOCK_TIMEOUT);
               lost_d  = lost_q + (lost_q != 8'hff ? 8'd1 : 8'd0);
            end
         end
         default: begin
            state_d = WAIT_LOCK;
            cnt_d   = CW'(LOCK_TIMEOUT);
         end
      endcase
   end
   // State, lock synchronizer and registered outputs; outputs follow the next state on the same edge
   always_ff @(posedge clk27 or negedge rstn) begin
      if (!rstn) begin
         state_q  <= WAIT_LOCK;
         cnt_q    <= CW'(LOCK_TIMEOUT);
         cfg_q    <= DEFAULT_CONFIG;
         pend_q   <= DEFAULT_CONFIG;
         err_q    <= 1'b0;
         lost_q   <= 8'd0;
         lock_m_q <= 1'b0;
         lock_s_q <= 1'b0;
         rdy_q    <= 1'b0;
         hrst_q   <= 1'b0;
         busy_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cfg_q    <= cfg_d;
         pend_q   <= pend_d;
         err_q    <= err_d;
         lost_q   <= lost_d;
         lock_m_q <= lock;
         lock_s_q <= lock_m_q;
         rdy_q    <= state_d == RUN;
         hrst_q   <= state_d == RUN;
         busy_q   <= state_d != RUN;
      end
   end
   assign req_ready    = rdy_q;
   assign clock_config = cfg_q;
   assign hdmi_rstn_o  = hrst_q;
   assign busy         = busy_q;
   assign cfg_err      = err_q;
   assign lost_cnt     = lost_q;
endmodule

// File: tb/tb_video_clock_seq.sv
// tb_video_clock_seq: directed vectors and sequences for the pixel-clock sequencer
module tb_video_clock_seq;
   logic       clk27 = 1'b0;
   logic       rstn, lock, req_valid;
   logic [3:0] req_config;
   logic       req_ready, hdmi_rstn_o, busy, cfg_err;
   logic [3:0] clock_config;
   logic [7:0] lost_cnt;
   int         checks = 0, failures = 0;

   video_clock_seq #(
      .DEFAULT_CONFIG(4'd0), .HOLD_CYCLES(4), .DROP_CYCLES(2),
      .SETTLE_CYCLES(8), .LOCK_TIMEOUT(64)
   ) dut (
      .clk27(clk27), .rstn(rstn), .lock(lock), .req_valid(req_valid),
      .req_config(req_config), .req_ready(req_ready), .clock_config(clock_config),
      .hdmi_rstn_o(hdmi_rstn_o), .busy(busy), .cfg_err(cfg_err), .lost_cnt(lost_cnt)
   );

   always #5 clk27 = ~clk27;

   typedef struct {
      logic       v;
      logic [3:0] c;
      logic       l;
      logic       h;
      logic [3:0] cfg;
      logic       rdy;
      logic       bsy;
   } vec_t;
   vec_t tbl[17];

   task automatic tick();
      @(posedge clk27);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic wait_hdmi(input logic v, input int max, output int n);
      n = 0;
      while (hdmi_rstn_o !== v && n < max) begin
         tick();
         n++;
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cfg"}, clock_config, 0);
      chk({tag, "_hdmi"}, hdmi_rstn_o, 0);
      chk({tag, "_ready"}, req_ready, 0);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_err"}, cfg_err, 0);
      chk({tag, "_lost"}, lost_cnt, 0);
   endtask

   initial begin
      int n, bad;
      // request 3 from RUN, lock low for 3 cycles while reprogramming, then relock
      tbl[0]  = '{1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1};
      tbl[1]  = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1};
      tbl[2]  = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1};
      tbl[3]  = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
      tbl[4]  = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1};
      tbl[5]  = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1};
      for (int i = 6; i < 16; i++) tbl[i] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1};
      tbl[16] = '{1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0};

      rstn = 1'b0; lock = 1'b1; req_valid = 1'b0; req_config = 4'd0;
      tick(); tick();
      chk_reset_vals("rst");
      rstn = 1'b1;
      wait_hdmi(1'b1, 40, n);
      chk("rst_release_latency", n, 11);
      chk("rst_release_cfg", clock_config, 0);
      chk("rst_release_ready", req_ready, 1);
      chk("rst_release_busy", busy, 0);

      for (int i = 0; i < 17; i++) begin
         req_valid = tbl[i].v; req_config = tbl[i].c; lock = tbl[i].l;
         tick();
         chk($sformatf("vec%0d_hdmi", i), hdmi_rstn_o, tbl[i].h);
         chk($sformatf("vec%0d_cfg", i), clock_config, tbl[i].cfg);
         chk($sformatf("vec%0d_ready", i), req_ready, tbl[i].rdy);
         chk($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
      end
      req_valid = 1'b0; lock = 1'b1;
      chk("vec_lost", lost_cnt, 0);

      // request 2 with lock gone: timeout 64 cycles after WAIT_LOCK entry
      req_valid = 1'b1; req_config = 4'd2; lock = 1'b0;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 69; i++) tick();
      chk("to_pre_err", cfg_err, 0);
      chk("to_pre_cfg", clock_config, 2);
      tick();
      chk("to_err", cfg_err, 1);
      chk("to_cfg", clock_config, 0);
      chk("to_lost", lost_cnt, 0);
      lock = 1'b1;
      wait_hdmi(1'b1, 40, n);
      chk("to_recover_latency", n, 11);
      chk("to_recover_err", cfg_err, 1);
      req_valid = 1'b1; req_config = 4'd0;
      tick();
      req_valid = 1'b0;
      chk("same_err_clr", cfg_err, 0);
      chk("same_hdmi", hdmi_rstn_o, 1);
      chk("same_busy", busy, 0);
      chk("same_ready", req_ready, 1);
      chk("same_cfg", clock_config, 0);

      // lock_s falls on the same edge a request is accepted: request wins
      lock = 1'b0;
      tick(); tick();
      req_valid = 1'b1; req_config = 4'd5;
      tick();
      req_valid = 1'b0;
      chk("race_busy", busy, 1);
      chk("race_lost", lost_cnt, 0);
      lock = 1'b1;
      wait_hdmi(1'b1, 40, n);
      chk("race_release", n, 15);
      chk("race_cfg", clock_config, 5);

      // lock loss in RUN, then a one-cycle glitch during SETTLE
      lock = 1'b0;
      wait_hdmi(1'b0, 10, n);
      chk("loss_latency", n, 3);
      chk("loss_lost", lost_cnt, 1);
      chk("loss_ready", req_ready, 0);
      lock = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("glitch_pre_busy", busy, 1);
      lock = 1'b0;
      tick();
      lock = 1'b1;
      wait_hdmi(1'b1, 40, n);
      chk("glitch_release", n, 11);

      // 300 lock drops saturate lost_cnt
      bad = 0;
      for (int k = 0; k < 300; k++) begin
         lock = 1'b0;
         wait_hdmi(1'b0, 10, n);
         if (n != 3) bad++;
         lock = 1'b1;
         wait_hdmi(1'b1, 30, n);
         if (n != 11) bad++;
      end
      chk("drops_timing", bad, 0);
      chk("lost_sat", lost_cnt, 255);

      // asynchronous reset in HOLD discards the pending config
      req_valid = 1'b1; req_config = 4'd7;
      tick();
      req_valid = 1'b0;
      tick();
      chk("hold_busy", busy, 1);
      #2 rstn = 1'b0;
      #1;
      chk_reset_vals("async");
      tick();
      rstn = 1'b1;
      wait_hdmi(1'b1, 40, n);
      chk("async_release", n, 11);
      chk("async_cfg", clock_config, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
